pipe_exe_md: RTL and testbench
==============================

Name: pipe_exe_md

Overview:
- EXE stage of the 5-stage pipelined CPU.
- Consumes the ID/EXE register outputs and produces the ALU/jal result and the write-back controls for the EXE/MEM register.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Asserts a stall that freezes PC, IF/ID and ID/EXE while a mult/div is in progress.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MD_CYCLES, 32, iterations per multiply/divide. Must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- ea  in  32  rs operand.
- eb  in  32  rt operand.
- eimm  in  32  sign/zero-extended immediate; bits [10:6] are shamt.
- epc4  in  32  PC+4 of the instruction in EXE.
- ealuc  in  4  ALU op.
- ealuimm  in  1  ALU B input selects eimm.
- eshift  in  1  ALU A input selects shamt.
- ejal  in  1  result is epc4+4.
- emdop  in  4  mult/div/HI/LO op.
- ewreg  in  1  register write enable from ID.
- em2reg  in  1  load select from ID.
- ewmem  in  1  store enable from ID.
- ern  in  5  destination register.
- ealu  out  32  EXE result to the EXE/MEM register.
- ewreg_o  out  1  ewreg & ~stall.
- ewmem_o  out  1  ewmem & ~stall.
- em2reg_o  out  1  em2reg passthrough.
- ern_o  out  5  ern passthrough.
- stall  out  1  freeze upstream stages.
- md_busy  out  1  state==BUSY, for debug/verification.

Behaviour:
- Reset is synchronous and active-high (clr), single clock clk.
- On a clr edge: state=IDLE, HI=LO=0, count=0, internal accumulators 0.
- stall is forced 0 while clr=1. ealu is combinational and has no reset value.
- ALU inputs:
  - A = eshift ? {27'b0, eimm[10:6]} : ea.
  - B = ealuimm ? eimm : eb.
- ealuc encoding:
  - x000 add; x100 sub (wrap, no overflow trap).
  - x001 and; x101 or; x010 xor.
  - x110 lui (B<<16).
  - 0011 sll; 0111 srl; 1111 sra. Shift amount is A[4:0]; the value shifted is B.
- Result priority: ejal → epc4+4; emdop=5 (mfhi) → HI; emdop=6 (mflo) → LO; else ALU output.
- emdop encoding: 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mfhi; 6 mflo; 7 mthi; 8 mtlo; 9-15 treated as none.
- mthi/mtlo: HI (or LO) <= ea at the next edge. No stall. A following mfhi/mflo sees the new value.
- start = (emdop in 1..4).
- FSM:
  - IDLE: if start, latch |ea|, |eb| (signed ops) or raw values (unsigned ops), latch the sign flags, count=0, go BUSY.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle. count increments; after count reaches MD_CYCLES-1, write HI/LO at that edge and go DONE.
  - DONE: one cycle, stall=0, no restart even though start is still high. Then go IDLE.
- stall = ~clr & ((IDLE & start) | BUSY).
- Stall length: 33 cycles. The mult/div instruction leaves EXE on the 34th edge after it entered.
- Multiply sign fix: for mult, negate the 64-bit product if the signs differ. {HI,LO} = product.
- Divide results:
  - LO = quotient, HI = remainder.
  - div: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (any signedness): LO=32'hFFFFFFFF, HI=ea.
  - 0x80000000 div -1: LO=0x80000000, HI=0.
- During stall, ewreg_o=ewmem_o=0 so the EXE/MEM register captures a bubble.
- Reset mid-operation: clr in BUSY or DONE aborts the op. Next cycle is IDLE, HI=LO=0, stall=0.
- HI/LO are never written by a none/ALU op.

Test Plan:
- ALU: ea=5, eimm=0xFFFFFFFD, ealuimm=1, ealuc=0000 → ealu=2. ealuc=1111, eshift=1, eimm[10:6]=4, eb=0x80000000 → ealu=0xF8000000.
- jal: ejal=1, epc4=0x00400010 → ealu=0x00400014, stall=0.
- mult -3×5 → stall high for 33 cycles, DONE cycle stall=0; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFF1; ewreg_o=0 during stall.
- divu 100/7 → LO=14, HI=2. div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 9/0 → LO=0xFFFFFFFF, HI=9. div 0x80000000/-1 → LO=0x80000000, HI=0.
- multu 0xFFFFFFFF×0xFFFFFFFF with clr pulsed at the 10th BUSY cycle → next cycle state IDLE, stall=0, HI=LO=0. Then mthi ea=0x1234 followed immediately by mfhi → ealu=0x1234.

Source files
------------

// File: rtl/pipe_exe_md.sv
// EXE stage of the 5-stage pipeline. It holds the ALU, the jal result mux,
// an iterative shift-add / restoring-divide unit with HI/LO registers, and
// the stall that freezes PC, IF/ID and ID/EXE while a mult/div is running.
module pipe_exe_md #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] eimm,
  input  logic [XLEN-1:0] epc4,
  input  logic [3:0]      ealuc,
  input  logic            ealuimm,
  input  logic            eshift,
  input  logic            ejal,
  input  logic [3:0]      emdop,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic            ewmem,
  input  logic [4:0]      ern,
  output logic [XLEN-1:0] ealu,
  output logic            ewreg_o,
  output logic            ewmem_o,
  output logic            em2reg_o,
  output logic [4:0]      ern_o,
  output logic            stall,
  output logic            md_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_CNT = 5'(MD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // acc_hi/acc_lo: partial product (mult) or remainder/quotient (div)
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        is_div_q, is_div_d, is_sgn_q, is_sgn_d, dz_q, dz_d;

  logic        start_s, op_sgn_s, op_div_s;
  logic [31:0] alu_a_s, alu_b_s, alu_y_s;
  logic [32:0] mul_sum_s, div_tmp_s, div_diff_s;
  logic        div_ok_s;
  logic [31:0] step_hi_s, step_lo_s;
  logic [63:0] prod_s, prod_fix_s;
  logic [31:0] quo_fix_s, rem_fix_s;

  assign start_s  = (emdop >= 4'd1) && (emdop <= 4'd4);
  assign op_sgn_s = (emdop == 4'd1) || (emdop == 4'd3);
  assign op_div_s = (emdop == 4'd3) || (emdop == 4'd4);

  // ALU operand selection and operation decode
  always_comb begin
    alu_a_s = eshift ? {27'd0, eimm[10:6]} : ea;
    alu_b_s = ealuimm ? eimm : eb;
    case (ealuc[2:0])
      3'b000:  alu_y_s = alu_a_s + alu_b_s;
      3'b100:  alu_y_s = alu_a_s - alu_b_s;
      3'b001:  alu_y_s = alu_a_s & alu_b_s;
      3'b101:  alu_y_s = alu_a_s | alu_b_s;
      3'b010:  alu_y_s = alu_a_s ^ alu_b_s;
      3'b110:  alu_y_s = {alu_b_s[15:0], 16'd0};
      3'b011:  alu_y_s = alu_b_s << alu_a_s[4:0];
      3'b111: begin
        if (ealuc[3]) begin
          alu_y_s = $unsigned($signed(alu_b_s) >>> alu_a_s[4:0]);
        end else begin
          alu_y_s = alu_b_s >> alu_a_s[4:0];
        end
      end
      default: alu_y_s = 32'd0;
    endcase
  end

  // One iteration of the mult/div datapath plus final sign correction
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_tmp_s  = {acc_hi_q, acc_lo_q[31]};
    div_diff_s = div_tmp_s - {1'b0, opb_q};
    div_ok_s   = ~div_diff_s[32];
    if (is_div_q) begin
      step_hi_s = div_ok_s ? div_diff_s[31:0] : div_tmp_s[31:0];
      step_lo_s = {acc_lo_q[30:0], div_ok_s};
    end else begin
      step_hi_s = mul_sum_s[32:1];
      step_lo_s = {mul_sum_s[0], acc_lo_q[31:1]};
    end
    prod_s     = {step_hi_s, step_lo_s};
    prod_fix_s = (is_sgn_q && (sa_q ^ sb_q)) ? (64'd0 - prod_s) : prod_s;
    // divide by zero leaves |dividend| as remainder, so the sign fix restores ea
    quo_fix_s  = dz_q ? 32'hFFFF_FFFF :
                 ((is_sgn_q && (sa_q ^ sb_q)) ? (32'd0 - step_lo_s) : step_lo_s);
    rem_fix_s  = (is_sgn_q && sa_q) ? (32'd0 - step_hi_s) : step_hi_s;
  end

  // FSM next state, operand latching and HI/LO updates
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          sa_d     = op_sgn_s & ea[31];
          sb_d     = op_sgn_s & eb[31];
          is_div_d = op_div_s;
          is_sgn_d = op_sgn_s;
          dz_d     = op_div_s && (eb == 32'd0);
          acc_hi_d = 32'd0;
          acc_lo_d = (op_sgn_s && ea[31]) ? (32'd0 - ea) : ea;
          opb_d    = (op_sgn_s && eb[31]) ? (32'd0 - eb) : eb;
          count_d  = 5'd0;
          state_d  = S_BUSY;
        end else if (emdop == 4'd7) begin
          hi_d = ea;
        end else if (emdop == 4'd8) begin
          lo_d = ea;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        count_d  = count_q + 5'd1;
        if (count_q == LAST_CNT) begin
          if (is_div_q) begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end else begin
            hi_d = prod_fix_s[63:32];
            lo_d = prod_fix_s[31:0];
          end
          count_d = 5'd0;
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opb_q    <= 32'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      dz_q     <= dz_d;
    end
  end

  // Result mux and write-back controls; bubbles are injected while stalled
  always_comb begin
    md_busy = (state_q == S_BUSY);
    stall   = ~clr & (((state_q == S_IDLE) & start_s) | md_busy);
    if (ejal) begin
      ealu = epc4 + 32'd4;
    end else if (emdop == 4'd5) begin
      ealu = hi_q;
    end else if (emdop == 4'd6) begin
      ealu = lo_q;
    end else begin
      ealu = alu_y_s;
    end
    ewreg_o  = ewreg & ~stall;
    ewmem_o  = ewmem & ~stall;
    em2reg_o = em2reg;
    ern_o    = ern;
  end

endmodule

// File: tb/tb_pipe_exe_md.sv
// Self-checking bench for pipe_exe_md: ALU vector table, randomized ALU and
// mult/div operations against a plain-arithmetic model, and hand sequences.
module tb_pipe_exe_md;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ea, eb, eimm, epc4;
  logic [3:0]  ealuc, emdop;
  logic        ealuimm, eshift, ejal, ewreg, em2reg, ewmem;
  logic [4:0]  ern;
  logic [31:0] ealu;
  logic        ewreg_o, ewmem_o, em2reg_o, stall, md_busy;
  logic [4:0]  ern_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_exe_md dut (
    .clk(clk), .clr(clr), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
    .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal),
    .emdop(emdop), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .ealu(ealu), .ewreg_o(ewreg_o), .ewmem_o(ewmem_o), .em2reg_o(em2reg_o),
    .ern_o(ern_o), .stall(stall), .md_busy(md_busy)
  );

  typedef struct {
    logic [31:0] a, b, imm, pc4;
    logic [3:0]  aluc;
    logic        aluimm, shift, jal;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: semantics straight from the operation list
  function automatic logic [31:0] alu_ref(input logic [31:0] a_in, b_in, imm, pc4,
                                          input logic [3:0] aluc,
                                          input logic aluimm, shift, jal);
    logic [31:0] a, b;
    int unsigned sh;
    longint sx;
    a  = shift ? {27'd0, imm[10:6]} : a_in;
    b  = aluimm ? imm : b_in;
    sh = a % 32;
    if (jal) return pc4 + 32'd4;
    case (aluc)
      4'b0000, 4'b1000: return a + b;
      4'b0100, 4'b1100: return a - b;
      4'b0001, 4'b1001: return a & b;
      4'b0101, 4'b1101: return a | b;
      4'b0010, 4'b1010: return a ^ b;
      4'b0110, 4'b1110: return b * 32'd65536;
      4'b0011:          return b * (32'd1 << sh);
      4'b0111:          return b / (32'd1 << sh);
      4'b1111: begin
        sx = longint'(int'(b));
        sx = sx - ((sx % (64'sd1 <<< sh) + (64'sd1 <<< sh)) % (64'sd1 <<< sh));
        return 32'(sx / (64'sd1 <<< sh));
      end
      default:          return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Reference mult/div returning {HI, LO}
  function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [31:0] a, b);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (op)
      4'd1: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic set_idle();
    ea = 32'd0; eb = 32'd0; eimm = 32'd0; epc4 = 32'd0;
    ealuc = 4'd0; emdop = 4'd0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0; ern = 5'd0;
  endtask

  // Issue a mult/div, measure the stall, then read back HI and LO
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, b, input string tag);
    logic [63:0] r;
    int sc, bc;
    r = md_ref(op, a, b);
    sc = 0;
    bc = 0;
    ea = a; eb = b; emdop = op; ejal = 1'b0; ewreg = 1'b1; ewmem = 1'b1;
    #4;
    chk({tag, "_ewreg_bubble"}, {31'd0, ewreg_o}, 32'd0);
    chk({tag, "_ewmem_bubble"}, {31'd0, ewmem_o}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (!stall) break;
      sc++;
      if (md_busy) bc++;
      next_cyc();
      #4;
    end
    chk({tag, "_stall_len"}, sc, 32'd33);
    chk({tag, "_busy_len"}, bc, 32'd32);
    chk({tag, "_done_ewreg"}, {31'd0, ewreg_o}, 32'd1);
    next_cyc();
    emdop = 4'd5; ea = 32'd0;
    #4;
    chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
    chk({tag, "_hi"}, ealu, r[63:32]);
    next_cyc();
    emdop = 4'd6;
    #4;
    chk({tag, "_lo"}, ealu, r[31:0]);
    next_cyc();
    emdop = 4'd0; ewreg = 1'b0; ewmem = 1'b0;
  endtask

  initial begin
    logic [3:0] aluc_list[13];
    logic [31:0] sp[6];
    logic [3:0] op;
    logic [31:0] a, b;

    aluc_list = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0001, 4'b0101, 4'b1001,
                  4'b0010, 4'b0110, 4'b1110, 4'b0011, 4'b0111, 4'b1111};
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};

    //          a             b             imm           pc4           aluc     imm   sh    jal   exp
    vecs[0]  = '{32'd5,        32'd0,        32'hFFFF_FFFD, 32'd0,       4'b0000, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[1]  = '{32'd0,        32'h8000_0000, 32'h0000_0100, 32'd0,      4'b1111, 1'b0, 1'b1, 1'b0, 32'hF800_0000};
    vecs[2]  = '{32'd0,        32'd0,        32'd0,        32'h0040_0010, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0040_0014};
    vecs[3]  = '{32'd3,        32'd5,        32'd0,        32'd0,        4'b0100, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[4]  = '{32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd0,      32'd0,        4'b0001, 1'b0, 1'b0, 1'b0, 32'h00F0_00FF};
    vecs[5]  = '{32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd0,      32'd0,        4'b0101, 1'b0, 1'b0, 1'b0, 32'hFFF0_FFFF};
    vecs[6]  = '{32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd0,      32'd0,        4'b0010, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00};
    vecs[7]  = '{32'd0,        32'd0,        32'h0000_ABCD, 32'd0,       4'b0110, 1'b1, 1'b0, 1'b0, 32'hABCD_0000};
    vecs[8]  = '{32'd0,        32'd1,        32'h0000_00C0, 32'd0,       4'b0011, 1'b0, 1'b1, 1'b0, 32'd8};
    vecs[9]  = '{32'd4,        32'h8000_0000, 32'd0,       32'd0,        4'b0111, 1'b0, 1'b0, 1'b0, 32'h0800_0000};
    vecs[10] = '{32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0,        4'b1000, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[11] = '{32'h0000_0024, 32'd1,       32'd0,        32'd0,        4'b0011, 1'b0, 1'b0, 1'b0, 32'd16};

    set_idle();
    clr = 1'b1;
    next_cyc();
    emdop = 4'd1;
    #4;
    chk("reset_stall_forced0", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, md_busy}, 32'd0);
    next_cyc();
    emdop = 4'd0;
    next_cyc();
    clr = 1'b0;
    emdop = 4'd5;
    #4;
    chk("reset_hi", ealu, 32'd0);
    next_cyc();
    emdop = 4'd6;
    #4;
    chk("reset_lo", ealu, 32'd0);
    next_cyc();
    emdop = 4'd0;

    // Directed ALU table
    for (int i = 0; i < 12; i++) begin
      ea = vecs[i].a; eb = vecs[i].b; eimm = vecs[i].imm; epc4 = vecs[i].pc4;
      ealuc = vecs[i].aluc; ealuimm = vecs[i].aluimm; eshift = vecs[i].shift;
      ejal = vecs[i].jal; ewreg = 1'b1;
      #4;
      chk($sformatf("alu_vec%0d", i), ealu, vecs[i].exp);
      chk($sformatf("alu_vec%0d_stall", i), {31'd0, stall}, 32'd0);
      next_cyc();
    end

    // Randomized ALU with passthroughs and unused md opcodes
    for (int i = 0; i < 200; i++) begin
      ea = $urandom; eb = $urandom; eimm = $urandom; epc4 = $urandom;
      ealuc = aluc_list[$urandom_range(0, 12)];
      ealuimm = 1'($urandom_range(0, 1)); eshift = 1'($urandom_range(0, 1));
      ejal = ($urandom_range(0, 7) == 0);
      emdop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      ewreg = 1'($urandom_range(0, 1)); ewmem = 1'($urandom_range(0, 1));
      em2reg = 1'($urandom_range(0, 1)); ern = 5'($urandom);
      #4;
      chk("alu_rand", ealu, alu_ref(ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal));
      chk("ctrl_rand", {21'd0, stall, ewreg_o, ewmem_o, em2reg_o, ern_o, 2'd0},
          {21'd0, 1'b0, ewreg, ewmem, em2reg, ern, 2'd0});
      next_cyc();
    end
    set_idle();

    // Directed mult/div cases
    run_md(4'd1, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    run_md(4'd4, 32'd100, 32'd7, "divu_100_7");
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_md(4'd3, 32'd9, 32'd0, "div_9_0");
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_md(4'd4, 32'hFFFF_FFF0, 32'd0, "divu_by0");
    run_md(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

    // Randomized mult/div with a bias toward edge operands
    for (int i = 0; i < 14; i++) begin
      op = 4'($urandom_range(1, 4));
      a = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      run_md(op, a, b, $sformatf("md_rand%0d_op%0d", i, op));
    end

    // Abort a multu with clr at the 10th busy cycle
    ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF; emdop = 4'd2;
    next_cyc();
    repeat (9) next_cyc();
    #4;
    chk("abort_busy_before", {31'd0, md_busy}, 32'd1);
    #1;
    clr = 1'b1;
    #1;
    chk("abort_stall_in_clr", {31'd0, stall}, 32'd0);
    next_cyc();
    clr = 1'b0; emdop = 4'd0;
    #4;
    chk("abort_busy_after", {31'd0, md_busy}, 32'd0);
    chk("abort_stall_after", {31'd0, stall}, 32'd0);
    next_cyc();
    emdop = 4'd5;
    #4;
    chk("abort_hi", ealu, 32'd0);
    next_cyc();
    emdop = 4'd6;
    #4;
    chk("abort_lo", ealu, 32'd0);
    next_cyc();

    // mthi/mtlo immediately followed by reads
    emdop = 4'd7; ea = 32'h0000_1234;
    #4;
    chk("mthi_nostall", {31'd0, stall}, 32'd0);
    next_cyc();
    emdop = 4'd5; ea = 32'd0;
    #4;
    chk("mthi_mfhi", ealu, 32'h0000_1234);
    next_cyc();
    emdop = 4'd8; ea = 32'hCAFE_0001;
    next_cyc();
    emdop = 4'd6; ea = 32'd0;
    #4;
    chk("mtlo_mflo", ealu, 32'hCAFE_0001);
    next_cyc();
    emdop = 4'd5;
    #4;
    chk("mtlo_hi_kept", ealu, 32'h0000_1234);
    next_cyc();
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
